line_buffer_3row: RTL and testbench
===================================

LINE_BUFFER_3ROW -- requirements
Module: line_buffer_3row

Interface
REQ-001 Parameter: DATA_WIDTH, 16, pixel/tap width in bits.
REQ-002 Parameter: IMG_WIDTH, 32, pixels per line (≥3).
REQ-003 Parameter: IMG_HEIGHT, 32, lines per frame (≥3).
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: sof  input  1  start-of-frame; qualified by valid_in; marks pixel (0,0).
REQ-007 Port: pixel_in  input  DATA_WIDTH  raster-order pixel.
REQ-008 Port: valid_in  input  1  pixel_in valid this cycle.
REQ-009 Port: row0  output  DATA_WIDTH  pixel at the same column, two lines above the current line.
REQ-010 Port: row1  output  DATA_WIDTH  pixel at the same column, one line above the current line.
REQ-011 Port: row2  output  DATA_WIDTH  current pixel.
REQ-012 Port: valid_out  output  1  row0..row2 valid; drives the downstream window stage's valid_in.
REQ-013 Port: eol  output  1  aligned with valid_out; tap column is IMG_WIDTH-1.
REQ-014 Port: frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-015 The block SHALL store two lines in two line memories, each IMG_WIDTH×DATA_WIDTH: LM0 (older) and LM1 (newer).
REQ-016 On each valid_in cycle at column c, the block SHALL read LM0[c] and LM1[c], write LM1[c] to LM0[c], and write pixel_in to LM1[c], with read-before-write semantics.
REQ-017 Latency SHALL be 1 cycle: row0=LM0[c], row1=LM1[c], row2=pixel_in, all registered together on the accepting edge.
REQ-018 The column counter SHALL increment per accepted pixel and wrap IMG_WIDTH-1→0; on wrap, the line counter SHALL increment.
REQ-019 valid_out SHALL be 1 in the cycle after an accepted pixel only when line counter ≥2; otherwise it SHALL be 0, including idle cycles.
REQ-020 On the accepted pixel with column IMG_WIDTH-1 and line IMG_HEIGHT-1, both counters SHALL return to 0, and frame_done SHALL pulse on the next cycle.
REQ-021 sof with valid_in SHALL force that pixel to be treated as column 0, line 0, regardless of counter state; line memories are not cleared, since their stale contents are masked by REQ-019.
REQ-022 Gaps in valid_in SHALL hold all counters and taps; memory SHALL not be written.
REQ-023 Outputs SHALL hold their last values while valid_out=0; consumers use valid_out only.
REQ-024 No backpressure exists; one pixel per cycle is accepted at full rate.

Reset
REQ-025 rst SHALL asynchronously clear the column counter, line counter, valid_out, eol, frame_done, row0, row1 and row2 to 0.
REQ-026 Line memory contents SHALL not be reset; after reset, the first frame SHALL not assert valid_out before line 2.
REQ-027 A rst asserted mid-frame SHALL abandon that frame; the next accepted pixel SHALL be column 0, line 0.

Structure
REQ-028 Default IMG_WIDTH/IMG_HEIGHT constants and the clog2-derived counter widths SHALL live in the shared dataflow package.
REQ-029 A sub-module line_mem (single-port, synchronous read-before-write, parameterised depth/width, RAM-inferable) SHALL be instantiated twice.

Verification
REQ-030 Ramp frame, IMG_WIDTH=4, IMG_HEIGHT=4, pixel=line*16+col, continuous valid -> first valid_out at pixel (2,0) with row0=0x00, row1=0x10, row2=0x20; exactly 8 valid_out cycles in total.
REQ-031 Same frame with valid_in toggling every other cycle -> identical tap sequence; valid_out never high in an idle-following cycle.
REQ-032 Last pixel (3,3) -> eol=1 with row0=0x13, row1=0x23, row2=0x33; frame_done pulses once on the next cycle; counters read 0.
REQ-033 Two back-to-back frames, second with sof -> no valid_out during lines 0–1 of frame 2; the frame-2 line-2 taps contain only frame-2 data.
REQ-034 rst asserted at pixel (2,1) -> all outputs 0 immediately; the next frame behaves as REQ-030.
REQ-035 sof asserted mid-line at (1,2) -> that pixel becomes (0,0); valid_out stays 0 for the next 2×IMG_WIDTH accepted pixels.

Source files
------------

// File: rtl/line_buffer_3row_pkg.sv
// rtl/line_buffer_3row_pkg.sv - shared dataflow constants and counter-width helper
package line_buffer_3row_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int IMG_WIDTH_DEF  = 32;
  localparam int IMG_HEIGHT_DEF = 32;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COL_W_DEF  = cnt_width(IMG_WIDTH_DEF);
  localparam int LINE_W_DEF = cnt_width(IMG_HEIGHT_DEF);

endpackage

// File: rtl/line_mem.sv
// rtl/line_mem.sv - single-port synchronous read-before-write line memory
module line_mem
  import line_buffer_3row_pkg::*;
#(
  parameter int DEPTH = IMG_WIDTH_DEF,
  parameter int WIDTH = DATA_WIDTH_DEF,
  parameter int AW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [WIDTH-1:0] rdata_q;

  // Read returns the old word at addr while the same access may overwrite it.
  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_buffer_3row.sv
// rtl/line_buffer_3row.sv - three-row vertical tap generator over two line memories
module line_buffer_3row
  import line_buffer_3row_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sof,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] row0,
  output logic [DATA_WIDTH-1:0] row1,
  output logic [DATA_WIDTH-1:0] row2,
  output logic                  valid_out,
  output logic                  eol,
  output logic                  frame_done
);

  localparam int COL_W  = cnt_width(IMG_WIDTH);
  localparam int LINE_W = cnt_width(IMG_HEIGHT);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(IMG_HEIGHT - 1);
  localparam logic [LINE_W-1:0] LINE_TAP0 = LINE_W'(2);

  logic [COL_W-1:0]      col_q, col_d, col_cur;
  logic [LINE_W-1:0]     line_q, line_d, line_cur;
  logic                  older_q, older_d;
  logic                  rd_sel_q;
  logic                  have_q;
  logic [DATA_WIDTH-1:0] pix_q;
  logic                  valid_q, eol_q, done_q;
  logic                  col_wrap, line_wrap, tap_line;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;

  // sof overrides the counters so that pixel lands at column 0, line 0.
  always_comb begin
    col_cur   = sof ? '0 : col_q;
    line_cur  = sof ? '0 : line_q;
    col_wrap  = (col_cur == COL_LAST);
    line_wrap = col_wrap && (line_cur == LINE_LAST);
    tap_line  = (line_cur >= LINE_TAP0);
  end

  // Next column/line position and memory role swap for an accepted pixel.
  // Instead of copying the newer line into the older memory, the two memories
  // trade roles at every line end: the older one is overwritten with the
  // incoming line, which then becomes the newer line.
  always_comb begin
    col_d   = col_q;
    line_d  = line_q;
    older_d = older_q;
    if (valid_in) begin
      if (col_wrap) begin
        col_d   = '0;
        line_d  = line_wrap ? '0 : line_cur + 1'b1;
        older_d = ~older_q;
      end else begin
        col_d   = col_cur + 1'b1;
        line_d  = line_cur;
      end
    end
  end

  // Counters, role bit and registered taps/flags; everything holds during gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q    <= '0;
      line_q   <= '0;
      older_q  <= 1'b0;
      rd_sel_q <= 1'b0;
      have_q   <= 1'b0;
      pix_q    <= '0;
      valid_q  <= 1'b0;
      eol_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      line_q  <= line_d;
      older_q <= older_d;
      if (valid_in) begin
        rd_sel_q <= older_q;
        have_q   <= 1'b1;
        pix_q    <= pixel_in;
        valid_q  <= tap_line;
        eol_q    <= tap_line && col_wrap;
        done_q   <= line_wrap;
      end else begin
        valid_q  <= 1'b0;
        eol_q    <= 1'b0;
        done_q   <= 1'b0;
      end
    end
  end

  line_mem #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_WIDTH),
    .AW    (COL_W)
  ) u_mem0 (
    .clk     (clk),
    .en_i    (valid_in),
    .we_i    (valid_in && !older_q),
    .addr_i  (col_cur),
    .wdata_i (pixel_in),
    .rdata_o (rdata0)
  );

  line_mem #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_WIDTH),
    .AW    (COL_W)
  ) u_mem1 (
    .clk     (clk),
    .en_i    (valid_in),
    .we_i    (valid_in && older_q),
    .addr_i  (col_cur),
    .wdata_i (pixel_in),
    .rdata_o (rdata1)
  );

  // The memory read registers are the row0/row1 tap registers; have_q forces
  // them to read as zero from reset until the first pixel refills them.
  always_comb begin
    row0 = '0;
    row1 = '0;
    if (have_q) begin
      row0 = rd_sel_q ? rdata1 : rdata0;
      row1 = rd_sel_q ? rdata0 : rdata1;
    end
  end

  assign row2       = pix_q;
  assign valid_out  = valid_q;
  assign eol        = eol_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// tb/tb_line_buffer_3row.sv - scoreboard bench for line_buffer_3row
module tb_line_buffer_3row;

  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          sof;
  logic [DW-1:0] pixel_in;
  logic          valid_in;
  logic [DW-1:0] row0, row1, row2;
  logic          valid_out, eol, frame_done;

  line_buffer_3row #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sof        (sof),
    .pixel_in   (pixel_in),
    .valid_in   (valid_in),
    .row0       (row0),
    .row1       (row1),
    .row2       (row2),
    .valid_out  (valid_out),
    .eol        (eol),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] r0;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic          eol;
    int            cyc;
  } tap_t;

  tap_t exp_q[$];
  int   fd_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   vo_count    = 0;

  logic [DW-1:0] fb [H][W];
  int ml = 0;
  int mc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: remember every pixel of the current frame by (line, col);
  // from line 2 on the taps are the same column two and one lines up.
  task automatic model_push(input logic s, input logic [DW-1:0] p);
    tap_t t;
    if (s) begin
      ml = 0;
      mc = 0;
    end
    fb[ml][mc] = p;
    if (ml >= 2) begin
      t.r0  = fb[ml-2][mc];
      t.r1  = fb[ml-1][mc];
      t.r2  = p;
      t.eol = (mc == W - 1);
      t.cyc = cyc + 1;
      exp_q.push_back(t);
    end
    if (mc == W - 1) begin
      mc = 0;
      if (ml == H - 1) begin
        ml = 0;
        fd_q.push_back(cyc + 1);
      end else begin
        ml++;
      end
    end else begin
      mc++;
    end
  endtask

  task automatic send(input logic s, input logic [DW-1:0] p);
    sof      = s;
    pixel_in = p;
    valid_in = 1'b1;
    model_push(s, p);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sof      = 1'b0;
      valid_in = 1'b0;
      pixel_in = DW'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ramp_frame(input bit gaps);
    for (int l = 0; l < H; l++) begin
      for (int c = 0; c < W; c++) begin
        send((l == 0) && (c == 0), DW'(l * 16 + c));
        if (gaps) idle(1);
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_row0"}, row0, 0);
    check({tag, "_row1"}, row1, 0);
    check({tag, "_row2"}, row2, 0);
    check({tag, "_valid_out"}, valid_out, 0);
    check({tag, "_eol"}, eol, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("midframe_rst");
    ml = 0;
    mc = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  tap_t e;
  int   fd_cyc;

  // Monitor: pops the scoreboard whenever the DUT presents taps or frame_done.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_out) begin
        vo_count++;
        if (exp_q.size() == 0) begin
          check("spurious_valid_out", valid_out, 0);
        end else begin
          e = exp_q.pop_front();
          check("tap_cycle", cyc, e.cyc);
          check("row0", row0, e.r0);
          check("row1", row1, e.r1);
          check("row2", row2, e.r2);
          check("eol", eol, e.eol);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("missing_valid_out", valid_out, 1);
      end
      check("eol_aligned", eol && !valid_out, 0);
      if (frame_done) begin
        if (fd_q.size() == 0) begin
          check("spurious_frame_done", frame_done, 0);
        end else begin
          fd_cyc = fd_q.pop_front();
          check("frame_done_cycle", cyc, fd_cyc);
        end
      end else if (fd_q.size() > 0 && fd_q[0] <= cyc) begin
        fd_cyc = fd_q.pop_front();
        check("missing_frame_done", frame_done, 1);
      end
    end
  end

  int base;

  initial begin
    rst      = 1'b1;
    sof      = 1'b0;
    valid_in = 1'b0;
    pixel_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(2);

    // Ramp frame at full rate: exactly 8 tap cycles.
    base = vo_count;
    ramp_frame(1'b0);
    idle(3);
    check("ramp_valid_count", vo_count - base, 8);

    // Same frame with a gap after every pixel.
    base = vo_count;
    ramp_frame(1'b1);
    idle(3);
    check("gapped_valid_count", vo_count - base, 8);

    // Two back-to-back random frames, the second opened with sof.
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < W * H; p++) begin
        send(p == 0, DW'($urandom));
      end
    end
    idle(3);

    // Reset after pixel (2,1), then a clean ramp frame.
    for (int p = 0; p < 2 * W + 2; p++) begin
      send(p == 0, DW'($urandom));
    end
    idle(1);
    do_reset();
    base = vo_count;
    ramp_frame(1'b0);
    idle(3);
    check("post_reset_valid_count", vo_count - base, 8);

    // sof mid-line at (1,2): no taps over the next 2*W accepted pixels.
    for (int p = 0; p < W + 2; p++) begin
      send(p == 0, DW'($urandom));
    end
    base = vo_count;
    for (int p = 0; p < 2 * W; p++) begin
      send(p == 0, DW'($urandom));
      if ($urandom_range(3) == 0) idle(1);
    end
    idle(2);
    check("midline_sof_valid_count", vo_count - base, 0);
    for (int p = 2 * W; p < W * H; p++) begin
      send(1'b0, DW'($urandom));
    end
    idle(3);

    // Random traffic with gaps and occasional stray sof.
    for (int p = 0; p < 300; p++) begin
      send($urandom_range(24) == 0, DW'($urandom));
      if ($urandom_range(3) == 0) idle($urandom_range(1, 2));
    end
    idle(4);

    check("taps_left_unseen", exp_q.size(), 0);
    check("frame_done_left_unseen", fd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
